// File: rtl/evu_pkg.sv
`default_nettype none
// ============================================================================
// evu_pkg
// ----------------------------------------------------------------------------
// Shared types for the event-unit time-slicing scheduler:
//   evu_sel_e          4-bit event-select codes driven onto the mux sel_line
//   evu_sched_state_e  scheduler FSM states
//   evu_ctr_cfg_t      per-counter configuration (select code + enable)
//   idx_width()        index width helper that never returns zero
// ----------------------------------------------------------------------------
// Revision: 1.0  initial release
// ============================================================================
package evu_pkg;

  // Codes 0 and 1 never assert on the mux output.
  typedef enum logic [3:0] {
    NONE        = 4'h0,
    RSVD1       = 4'h1,
    ICACHE_MISS = 4'h2,
    DCACHE_MISS = 4'h3,
    ITLB_MISS   = 4'h4,
    DTLB_MISS   = 4'h5,
    BR_MISPRED  = 4'h6,
    BR_TAKEN    = 4'h7,
    LD_RETIRE   = 4'h8,
    ST_RETIRE   = 4'h9,
    STALL_MEM   = 4'hA,
    STALL_DEP   = 4'hB,
    EXCEPTION   = 4'hC,
    PIPE_FLUSH  = 4'hD,
    INSN_RETIRE = 4'hE,
    IF_EMPTY    = 4'hF
  } evu_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2
  } evu_sched_state_e;

  typedef struct packed {
    evu_sel_e sel;
    logic     en;
  } evu_ctr_cfg_t;

  // $clog2 of 1 is 0, which would give zero-width index buses.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/evu_rr_pick.sv
`default_nettype none
// ============================================================================
// evu_rr_pick
// ----------------------------------------------------------------------------
// Combinational round-robin picker. Searches en[] starting at the index after
// cur and wrapping around; cur itself is the last candidate, so a lone
// enabled counter picks itself again.
//   en     in   N        enable vector
//   cur    in   IDX_W    current index (search starts at cur+1)
//   nxt    out  IDX_W    selected index (cur when nothing is enabled)
//   valid  out  1        at least one enable is set
// ----------------------------------------------------------------------------
// Revision: 1.0  initial release
// ============================================================================
module evu_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     en,
  input  logic [IDX_W-1:0] cur,
  output logic [IDX_W-1:0] nxt,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest enabled
  // index is the last one written.
  always_comb begin
    nxt   = cur;
    valid = 1'b0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IDX_W'((int'(cur) + k) % N);
      if (en[cand]) begin
        nxt   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/evu_sched.sv
`default_nettype none
// ============================================================================
// evu_sched
// ----------------------------------------------------------------------------
// Time-slicing scheduler sharing one registered event-selection mux among
// NUM_CTR logical counters. The owner's select code is driven for one SETTLE
// cycle (mux output still stale, sample dropped) plus SLICE_LEN COUNT cycles,
// then ownership moves round-robin to the next enabled counter.
//
// Ports
//   clk_i        in   1        clock
//   rst_i        in   1        synchronous reset, active-high
//   cfg_we_i     in   1        config write strobe
//   cfg_idx_i    in   IDX_W    counter being configured
//   cfg_sel_i    in   4        event-select code
//   cfg_en_i     in   1        enable for cfg_idx_i
//   clr_i        in   1        clear counter value and overflow flag
//   clr_idx_i    in   IDX_W    counter to clear
//   rd_idx_i     in   IDX_W    read select
//   rd_data_o    out  CTR_W    counter value, registered
//   rd_ovf_o     out  1        overflow flag, registered with rd_data_o
//   sel_line_o   out  4        event select to mux, 0 when idle
//   evu_event_i  in   1        registered event output of mux
//   owner_o      out  IDX_W    current owner index
//   busy_o       out  1        high in SETTLE/COUNT
//   irq_o        out  1        registered OR of overflow flags
//
// Build option: define EVU_SCHED_OVF_IRQ_EN to enable irq_o; otherwise it is
// tied low while overflow flags remain readable.
// ----------------------------------------------------------------------------
// Revision: 1.0  initial release
// ============================================================================
module evu_sched
  import evu_pkg::*;
#(
  parameter  int NUM_CTR   = 4,
  parameter  int CTR_W     = 32,
  parameter  int SLICE_LEN = 16,
  localparam int IDX_W     = idx_width(NUM_CTR)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_idx_i,
  input  logic [3:0]       cfg_sel_i,
  input  logic             cfg_en_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CTR_W-1:0] rd_data_o,
  output logic             rd_ovf_o,
  output logic [3:0]       sel_line_o,
  input  logic             evu_event_i,
  output logic [IDX_W-1:0] owner_o,
  output logic             busy_o,
  output logic             irq_o
);

  localparam int SL_W = idx_width(SLICE_LEN);

  evu_sched_state_e   state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [SL_W-1:0]    slice_q, slice_d;

  evu_ctr_cfg_t       cfg [NUM_CTR];
  logic [CTR_W-1:0]   cnt [NUM_CTR];
  logic [NUM_CTR-1:0] ovf;
  logic [NUM_CTR-1:0] en;
  logic [NUM_CTR-1:0] en_nxt;

  logic               abort;
  logic               inc_en;
  logic [IDX_W-1:0]   pick_cur;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  logic [CTR_W-1:0]   rd_data_q;
  logic               rd_ovf_q;

  // Enable vector as it will be after this edge; scheduling decisions look
  // at it so a counter disabled this cycle is never handed ownership.
  always_comb begin
    en_nxt = en;
    if (cfg_we_i) begin
      en_nxt[cfg_idx_i] = cfg_en_i;
    end
  end

  // Any write to the owner's config restarts its slice with a fresh SETTLE.
  assign abort  = cfg_we_i && (cfg_idx_i == owner_q) && (state_q != IDLE);
  assign inc_en = (state_q == COUNT) && !abort && evu_event_i;

  // From IDLE, searching after the last index yields the lowest enabled one.
  assign pick_cur = (state_q == IDLE) ? IDX_W'(NUM_CTR - 1) : owner_q;

  evu_rr_pick #(
    .N     (NUM_CTR),
    .IDX_W (IDX_W)
  ) u_pick (
    .en    (en_nxt),
    .cur   (pick_cur),
    .nxt   (pick_idx),
    .valid (pick_valid)
  );

  // --------------------------------------------------------------------------
  // Per-counter configuration, count and sticky overflow
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CTR; i++) begin : g_ctr
    evu_ctr_cfg_t     cfg_q;
    logic [CTR_W-1:0] cnt_q;
    logic             ovf_q;
    logic             wr_hit;
    logic             clr_hit;
    logic             inc_hit;

    assign wr_hit  = cfg_we_i && (cfg_idx_i == IDX_W'(i));
    assign clr_hit = clr_i && (clr_idx_i == IDX_W'(i));
    assign inc_hit = inc_en && (owner_q == IDX_W'(i));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cfg_q <= '0;
      end else if (wr_hit) begin
        cfg_q <= '{sel: evu_sel_e'(cfg_sel_i), en: cfg_en_i};
      end
    end

    // Clear has priority over both increment and overflow.
    always_ff @(posedge clk_i) begin
      if (rst_i || clr_hit) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (inc_hit) begin
        cnt_q <= cnt_q + 1'b1;
        if (&cnt_q) begin
          ovf_q <= 1'b1;
        end
      end
    end

    assign cfg[i] = cfg_q;
    assign cnt[i] = cnt_q;
    assign ovf[i] = ovf_q;
    assign en[i]  = cfg_q.en;
  end

  // --------------------------------------------------------------------------
  // Scheduler FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      slice_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      slice_q <= slice_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    slice_d = slice_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = SETTLE;
          owner_d = pick_idx;
        end
      end
      SETTLE, COUNT: begin
        if (abort) begin
          // Owner keeps the mux if it is still enabled after the write.
          if (en_nxt[owner_q]) begin
            state_d = SETTLE;
          end else if (pick_valid) begin
            state_d = SETTLE;
            owner_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end else if (state_q == SETTLE) begin
          state_d = COUNT;
          slice_d = SL_W'(SLICE_LEN - 1);
        end else begin
          slice_d = slice_q - 1'b1;
          if (slice_q == '0) begin
            if (pick_valid) begin
              state_d = SETTLE;
              owner_d = pick_idx;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read port: shows register contents from before this edge's update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      rd_data_q <= cnt[rd_idx_i];
      rd_ovf_q  <= ovf[rd_idx_i];
    end
  end

`ifdef EVU_SCHED_OVF_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |ovf;
    end
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign rd_data_o  = rd_data_q;
  assign rd_ovf_o   = rd_ovf_q;
  assign sel_line_o = (state_q == IDLE) ? 4'h0 : cfg[owner_q].sel;
  assign owner_o    = owner_q;
  assign busy_o     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_evu_sched.sv
`default_nettype none
// ============================================================================
// tb_evu_sched
// ----------------------------------------------------------------------------
// Directed bench for evu_sched. Stimulus pushes hand-computed expectations,
// tagged with the cycle they must appear in, into a scoreboard queue; a
// negedge monitor pops and compares them against the DUT outputs.
// CTR_W is reduced to 8 so counter wrap is reachable in a few hundred cycles.
// ----------------------------------------------------------------------------
// Revision: 1.0  initial release
// ============================================================================
module tb_evu_sched;

  localparam int NUM_CTR   = 4;
  localparam int CTR_W     = 8;
  localparam int SLICE_LEN = 16;

`ifdef EVU_SCHED_OVF_IRQ_EN
  localparam logic [31:0] IRQ_ON = 32'd1;
`else
  localparam logic [31:0] IRQ_ON = 32'd0;
`endif

  localparam int K_SEL   = 0;
  localparam int K_OWNER = 1;
  localparam int K_BUSY  = 2;
  localparam int K_RD    = 3;
  localparam int K_OVF   = 4;
  localparam int K_IRQ   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [1:0]       cfg_idx;
  logic [3:0]       cfg_sel;
  logic             cfg_en;
  logic             clr;
  logic [1:0]       clr_idx;
  logic [1:0]       rd_idx;
  logic [CTR_W-1:0] rd_data;
  logic             rd_ovf;
  logic [3:0]       sel_line;
  logic             evu_event;
  logic [1:0]       owner;
  logic             busy;
  logic             irq;

  evu_sched #(
    .NUM_CTR   (NUM_CTR),
    .CTR_W     (CTR_W),
    .SLICE_LEN (SLICE_LEN)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_sel_i   (cfg_sel),
    .cfg_en_i    (cfg_en),
    .clr_i       (clr),
    .clr_idx_i   (clr_idx),
    .rd_idx_i    (rd_idx),
    .rd_data_o   (rd_data),
    .rd_ovf_o    (rd_ovf),
    .sel_line_o  (sel_line),
    .evu_event_i (evu_event),
    .owner_o     (owner),
    .busy_o      (busy),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          cyc;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic string kname(input int k);
    case (k)
      K_SEL:   return "sel_line";
      K_OWNER: return "owner";
      K_BUSY:  return "busy";
      K_RD:    return "rd_data";
      K_OVF:   return "rd_ovf";
      K_IRQ:   return "irq";
      default: return "unknown";
    endcase
  endfunction

  // Insert keeping the queue ordered by target cycle.
  task automatic push(input int kind, input logic [31:0] e, input int at_cyc);
    exp_t it;
    int   pos;
    it.cyc  = at_cyc;
    it.kind = kind;
    it.exp  = e;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].cyc > at_cyc) pos--;
    sb.insert(pos, it);
  endtask

  task automatic chk(input int kind, input logic [31:0] e);
    push(kind, e, cyc);
  endtask

  task automatic rd(input int idx, input logic [31:0] d, input logic [31:0] o);
    rd_idx = 2'(idx);
    push(K_RD, d, cyc + 1);
    push(K_OVF, o, cyc + 1);
  endtask

  task automatic cfg_write(input int idx, input logic [3:0] sel, input logic en);
    cfg_we  = 1'b1;
    cfg_idx = 2'(idx);
    cfg_sel = sel;
    cfg_en  = en;
  endtask

  // Advance to cycle t; one-shot strobes drop after each edge.
  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      clr    = 1'b0;
    end
  endtask

  // Monitor: compare every expectation due in the current cycle.
  exp_t        mon_it;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_it = sb.pop_front();
      case (mon_it.kind)
        K_SEL:   mon_act = 32'(sel_line);
        K_OWNER: mon_act = 32'(owner);
        K_BUSY:  mon_act = 32'(busy);
        K_RD:    mon_act = 32'(rd_data);
        K_OVF:   mon_act = 32'(rd_ovf);
        K_IRQ:   mon_act = 32'(irq);
        default: mon_act = 'x;
      endcase
      checks++;
      if (mon_it.cyc != cyc || mon_act !== mon_it.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%0h want=%0h", kname(mon_it.kind), mon_it.cyc, mon_act, mon_it.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  // Anchor cycles of each scenario.
  localparam int W = 10;        // single counter, then owner disable
  localparam int A = W + 50;    // two counters round-robin
  localparam int B = A + 50;    // overflow on ctr1
  localparam int C = B + 280;   // clear coincident with event

  int w_off [7] = '{17, 18, 19, 20, 35, 36, 37};
  int w_exp [7] = '{15, 16, 16, 17, 32, 32, 33};

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_en = 1'b0;
    clr = 1'b0; clr_idx = '0; rd_idx = '0; evu_event = 1'b0;

    // Reset state
    at(3);
    rst = 1'b0;
    chk(K_SEL, 0); chk(K_BUSY, 0); chk(K_OWNER, 0); chk(K_IRQ, 0);
    chk(K_RD, 0); chk(K_OVF, 0);
    for (int i = 0; i < NUM_CTR; i++) begin
      at(3 + i);
      rd(i, 0, 0);
    end

    // Single counter: SETTLE then 16 counted cycles, period 17
    at(W);
    cfg_write(0, 4'h3, 1'b1);
    evu_event = 1'b1;
    chk(K_SEL, 0); chk(K_BUSY, 0);
    at(W + 1);
    chk(K_SEL, 3); chk(K_BUSY, 1); chk(K_OWNER, 0);
    for (int k = 0; k < 7; k++) begin
      at(W + w_off[k]);
      rd(0, 32'(w_exp[k]), 0);
      chk(K_BUSY, 1);
    end

    // Disable the lone owner mid-COUNT: abort to IDLE, value retained
    at(W + 40);
    cfg_write(0, 4'h3, 1'b0);
    chk(K_SEL, 3);
    at(W + 41);
    chk(K_SEL, 0); chk(K_BUSY, 0); chk(K_OWNER, 0);
    rd(0, 36, 0);
    at(W + 44);
    rd(0, 36, 0);
    at(W + 45);
    evu_event = 1'b0;

    // Two counters: owner sequence 0, 2, 0
    at(A);
    cfg_write(0, 4'h3, 1'b1);
    evu_event = 1'b1;
    at(A + 1);
    cfg_write(2, 4'h5, 1'b1);
    chk(K_OWNER, 0); chk(K_SEL, 3); chk(K_BUSY, 1);
    at(A + 17);
    chk(K_OWNER, 0); chk(K_SEL, 3);
    at(A + 18);
    chk(K_OWNER, 2); chk(K_SEL, 5);
    at(A + 34);
    chk(K_OWNER, 2); chk(K_SEL, 5);
    at(A + 35);
    chk(K_OWNER, 0); chk(K_SEL, 3);
    at(A + 36);
    cfg_write(0, 4'h3, 1'b0);
    at(A + 37);
    chk(K_OWNER, 2); chk(K_SEL, 5); chk(K_BUSY, 1);
    cfg_write(2, 4'h5, 1'b0);
    at(A + 38);
    chk(K_BUSY, 0); chk(K_SEL, 0);
    evu_event = 1'b0;
    at(A + 40); rd(0, 52, 0);
    at(A + 41); rd(1, 0, 0);
    at(A + 42); rd(2, 16, 0);
    at(A + 43); rd(3, 0, 0);

    // Overflow: 255 events bring ctr1 to all-ones, the 256th wraps it
    at(B);
    cfg_write(1, 4'h4, 1'b1);
    evu_event = 1'b1;
    at(B + 1);
    chk(K_OWNER, 1); chk(K_SEL, 4);
    at(B + 272);
    rd(1, 8'hFF, 0);
    at(B + 273);
    rd(1, 0, 1);
    chk(K_IRQ, 0);
    at(B + 274);
    chk(K_IRQ, IRQ_ON);

    // Clear coincident with an event on the owner
    at(C);
    clr = 1'b1; clr_idx = 2'd1;
    rd(1, 6, 1);
    at(C + 1);
    rd(1, 0, 0);
    chk(K_IRQ, IRQ_ON);
    at(C + 2);
    rd(1, 1, 0);
    chk(K_IRQ, 0);
    at(C + 3);
    cfg_write(1, 4'h4, 1'b0);
    at(C + 4);
    chk(K_BUSY, 0); chk(K_SEL, 0);
    evu_event = 1'b0;
    at(C + 8);
    rd(1, 2, 0);

    at(C + 10);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
      checks   += sb.size();
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
